// File: rtl/controlador_estados.sv
// controlador_estados: activity controller for the virtual pet.
// Turns debounced button levels into rising-edge requests, selects the
// one-hot activity code `estado`, ends activities on a full attribute or
// timeout, detects death after a run of zero attributes, and registers a
// low-attribute warning.
// Optional build macro CONTROLADOR_ESTADOS_REVIVER_EN: holding all three
// buttons high while MORTO revives the pet to OCIOSO.
module controlador_estados #(
  parameter logic [7:0]  MAX_ATRIB     = 8'd100,
  parameter logic [7:0]  LIMIAR_ALERTA = 8'd20,
  parameter logic [23:0] DURACAO       = 24'd1_000_000,
  parameter logic [23:0] TEMPO_MORTE   = 24'd500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_dormir,
  input  logic       btn_comer,
  input  logic       btn_aula,
  input  logic [7:0] fome,
  input  logic [7:0] felicidade,
  input  logic [7:0] sono,
  output logic [3:0] estado,
  output logic       alerta
);

  typedef enum logic [3:0] {
    OCIOSO     = 4'b0000,
    DORMINDO   = 4'b0001,
    COMENDO    = 4'b0010,
    DANDO_AULA = 4'b0100,
    MORTO      = 4'b1000
  } estado_t;

  estado_t     estado_q, estado_d;
  logic [23:0] timer_q, timer_d;
  logic [23:0] morte_cnt_q, morte_cnt_d;
  logic [2:0]  btn_q, btn_d;
  logic        alerta_q, alerta_d;

  logic        ev_dormir, ev_comer, ev_aula;
  logic        ha_evento;
  estado_t     alvo;
  logic [7:0]  atrib_fim;
  logic        cond_zero;
  logic        morte;
  logic [23:0] morte_cnt_inc;
  logic        baixo;

  // Rising-edge requests and priority selection (dormir > comer > aula).
  always_comb begin
    ev_dormir = btn_dormir & ~btn_q[2];
    ev_comer  = btn_comer  & ~btn_q[1];
    ev_aula   = btn_aula   & ~btn_q[0];
    ha_evento = ev_dormir | ev_comer | ev_aula;
    alvo      = OCIOSO;
    if (ev_dormir)     alvo = DORMINDO;
    else if (ev_comer) alvo = COMENDO;
    else if (ev_aula)  alvo = DANDO_AULA;
  end

  // Attribute that finishes the current activity, death term and warning term.
  always_comb begin
    atrib_fim = '0;
    case (estado_q)
      DORMINDO:   atrib_fim = sono;
      COMENDO:    atrib_fim = fome;
      DANDO_AULA: atrib_fim = felicidade;
      default:    atrib_fim = '0;
    endcase
    cond_zero     = (fome == 8'd0) | (sono == 8'd0) | (felicidade == 8'd0);
    morte_cnt_inc = (morte_cnt_q == '1) ? morte_cnt_q : morte_cnt_q + 24'd1;
    // Dies on the edge that completes TEMPO_MORTE consecutive true samples.
    morte         = cond_zero && (({1'b0, morte_cnt_q} + 25'd1) >= {1'b0, TEMPO_MORTE});
    baixo         = (fome < LIMIAR_ALERTA) | (sono < LIMIAR_ALERTA) |
                    (felicidade < LIMIAR_ALERTA);
  end

  // Next-state, activity timer, death counter and button history.
  always_comb begin
    estado_d    = estado_q;
    timer_d     = timer_q;
    morte_cnt_d = cond_zero ? morte_cnt_inc : '0;
    btn_d       = {btn_dormir, btn_comer, btn_aula};
    case (estado_q)
      MORTO: begin
`ifdef CONTROLADOR_ESTADOS_REVIVER_EN
        if (btn_dormir && btn_comer && btn_aula) begin
          estado_d    = OCIOSO;
          timer_d     = '0;
          morte_cnt_d = '0;
          btn_d       = '1;
        end
`endif
      end
      OCIOSO, DORMINDO, COMENDO, DANDO_AULA: begin
        if (morte) begin
          estado_d = MORTO;
        end else if (ha_evento && (alvo == estado_q)) begin
          estado_d = OCIOSO;
          timer_d  = '0;
        end else if (ha_evento) begin
          estado_d = alvo;
          timer_d  = DURACAO - 24'd1;
        end else if (estado_q == OCIOSO) begin
          timer_d  = '0;
        end else if ((atrib_fim >= MAX_ATRIB) || (timer_q == '0)) begin
          estado_d = OCIOSO;
          timer_d  = '0;
        end else begin
          timer_d  = timer_q - 24'd1;
        end
      end
      default: begin
        estado_d = OCIOSO;
        timer_d  = '0;
      end
    endcase
    alerta_d = baixo && (estado_d != MORTO);
  end

  // State registers; button history resets high so a held button cannot fire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q    <= OCIOSO;
      timer_q     <= '0;
      morte_cnt_q <= '0;
      btn_q       <= '1;
      alerta_q    <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      timer_q     <= timer_d;
      morte_cnt_q <= morte_cnt_d;
      btn_q       <= btn_d;
      alerta_q    <= alerta_d;
    end
  end

  assign estado = estado_q;
  assign alerta = alerta_q;

endmodule

// File: doc/controlador_estados.md
Name: controlador_estados

Overview:
- Drives the one-hot activity code `estado` that the attribute controller consumes.
- Reads back fome/felicidade/sono from it and takes three user buttons.
- Decides sleeping, eating, teaching or idle, and detects death.
- Sits between the button debouncers and the attribute controller; the same `estado` also feeds the display logic.

Parameters:
- MAX_ATRIB, 8'd100, attribute value that ends the matching activity.
- LIMIAR_ALERTA, 8'd20, any attribute below this value raises `alerta`.
- DURACAO, 24'd1_000_000, maximum clk cycles one activity lasts.
- TEMPO_MORTE, 24'd500_000, consecutive cycles with any attribute at 0 before death.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- btn_dormir  input  1  sleep request, synchronous level, already debounced.
- btn_comer  input  1  eat request, synchronous level.
- btn_aula  input  1  teach request, synchronous level.
- fome  input  8  hunger attribute, 0..100.
- felicidade  input  8  happiness attribute, 0..100.
- sono  input  8  rest attribute, 0..100.
- estado  output  4  one-hot state: OCIOSO=0000, DORMINDO=0001, COMENDO=0010, DANDO_AULA=0100, MORTO=1000.
- alerta  output  1  registered low-attribute warning.

Behaviour:
- Reset (async assert, sync release):
  - estado=OCIOSO, alerta=0.
  - Activity timer=0, death counter=0.
  - Button history registers=1, so a button held through reset release never fires.
- Button edges: ev_x = btn_x & ~btn_x_q, with btn_x_q registered every cycle. A rising level sampled at edge N updates estado at edge N (one sample of latency).
- Simultaneous edges: priority dormir > comer > aula; the lower-priority edges are discarded.
- Activity states (DORMINDO, COMENDO, DANDO_AULA) and their finishing attributes:
  - DORMINDO ends on sono.
  - COMENDO ends on fome.
  - DANDO_AULA ends on felicidade.
- Transitions, first match wins:
  1. MORTO: stays MORTO until rst, or until revive when the optional feature is compiled in.
  2. Death condition (see below) → MORTO.
  3. Edge for the current activity → OCIOSO (toggle off).
  4. Edge for a different activity (from OCIOSO or any activity) → that activity; timer loads DURACAO-1.
  5. In an activity with finishing attribute >= MAX_ATRIB → OCIOSO.
  6. In an activity with timer==0 → OCIOSO.
  7. Otherwise: timer decrements in activities and holds at 0 in OCIOSO.
- Death counter (24 bit):
  - Increments while (fome==0 | sono==0 | felicidade==0) and clears when that term is false.
  - Condition true at TEMPO_MORTE consecutive edges → estado=MORTO at the last of those edges.
  - Counter saturates and never wraps.
  - In MORTO, button edges are ignored and the timer holds.
- alerta:
  - Next value = (fome<LIMIAR_ALERTA | sono<LIMIAR_ALERTA | felicidade<LIMIAR_ALERTA) & (next estado != MORTO).
  - Comparisons are unsigned 8-bit; no arithmetic on the attributes.
- Reset mid-activity: immediate return to reset values; no pending edge survives.
- estado is always one of the five legal codes; any illegal code → OCIOSO on the next edge.

Optional Feature:
- Macro: CONTROLADOR_ESTADOS_REVIVER_EN.
- Defined: in MORTO, all three buttons sampled high on the same edge → estado=OCIOSO, death counter and timer cleared, btn_*_q set to 1. If the death condition still holds, the counter restarts from 0.
- Undefined: MORTO is left only by rst.

Test Plan (parameters overridden: DURACAO=8, TEMPO_MORTE=4, LIMIAR_ALERTA=20):
- Reset, attributes 50/50/50, pulse btn_comer one cycle → estado=0010 at the sampling edge; with fome held at 50, estado=0000 exactly 8 edges later (timer expiry).
- In COMENDO set fome=100 → estado=0000 on the next edge. Pulse btn_dormir then btn_dormir again → 0001, then 0000 (toggle).
- Rising edges on btn_aula and btn_dormir on the same edge → estado=0001. Later btn_aula edge in DORMINDO → 0100 with the timer reloaded to 7.
- Set sono=0 for 3 edges then 1 → no death, counter cleared. Set sono=0 for 4 edges → estado=1000. Further button edges leave estado=1000, and alerta=0.
- fome=19 in OCIOSO → alerta=1 next edge; fome=20 → alerta=0. Assert rst asynchronously mid-DANDO_AULA → estado=0000 and alerta=0 without a clock edge.
- With REVIVER_EN defined, in MORTO hold all buttons high one edge → estado=0000. Without the macro, the same stimulus leaves estado=1000. Holding btn_comer high through reset release produces no COMENDO entry in either build.
